// File: rtl/bus_responder_if.sv
// ---------------------------------------------------------------------------
// bus_responder_if
//   Signal bundle between the CPU bus / TX consumer and bus_responder.
//
//   CPU bus:
//     address  word address from the CPU
//     datao    write data from the CPU
//     rw       1 = read, 0 = write (write commits on the rising edge)
//     data     combinational read data back to the CPU
//   TX stream (valid/ready):
//     tx_data  FIFO head word
//     tx_valid FIFO not empty
//     tx_ready consumer accepts the head word
//
//   Handshake: a word transfers on a rising edge where tx_valid && tx_ready.
//   While tx_valid=1 and tx_ready=0 the responder holds tx_data stable.
//   tx_valid never depends on tx_ready.
//
//   Modports:
//     master  the CPU / consumer side
//     slave   the responder (bus_responder)
// ---------------------------------------------------------------------------
interface bus_responder_if;
    logic [31:0] address;
    logic [31:0] datao;
    logic        rw;
    logic [31:0] data;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output address, datao, rw, tx_ready,
        input  data, tx_data, tx_valid
    );

    modport slave (
        input  address, datao, rw, tx_ready,
        output data, tx_data, tx_valid
    );
endinterface

// File: rtl/bus_responder.sv
// ---------------------------------------------------------------------------
// bus_responder
//   Memory-side responder for the CPU bus. Holds a word-addressed RAM and a
//   small MMIO page:
//     IO_BASE+0  TXDATA  write pushes into the TX FIFO, reads 0
//     IO_BASE+1  STATUS  {29'b0, overflow, tx_empty, tx_full};
//                        writing datao[2]=1 clears the sticky overflow flag
//     IO_BASE+2  CYCLES  free-running cycle counter; a write loads it
//   Any other address outside the RAM is unmapped (reads 0, writes ignored).
//   The TX FIFO drains to an external consumer over valid/ready.
//
//   Parameters:
//     ADDR_BITS   RAM holds 2**ADDR_BITS words (must be < 32)
//     IO_BASE     word address of the MMIO page
//     FIFO_DEPTH  TX FIFO entries, power of two and >= 2
//
//   Ports:
//     clock   rising-edge clock for all state
//     reset   synchronous, active-high reset
//     bus     bus_responder_if.slave (address/datao/rw/data,
//             tx_data/tx_valid/tx_ready)
// ---------------------------------------------------------------------------
module bus_responder #(
    parameter int          ADDR_BITS  = 8,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    bus_responder_if.slave  bus
);

    localparam int RAM_WORDS = 1 << ADDR_BITS;
    localparam int IDX_W     = $clog2(FIFO_DEPTH);
    // One extra pointer bit distinguishes full from empty when indices match.
    localparam int PTR_W     = IDX_W + 1;

    localparam logic [31:0] TXDATA_ADDR = IO_BASE;
    localparam logic [31:0] STATUS_ADDR = IO_BASE + 32'd1;
    localparam logic [31:0] CYCLES_ADDR = IO_BASE + 32'd2;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic ram_sel;
    logic txdata_sel;
    logic status_sel;
    logic cycles_sel;
    logic wr_en;

    assign ram_sel    = (bus.address[31:ADDR_BITS] == '0);
    assign txdata_sel = (bus.address == TXDATA_ADDR);
    assign status_sel = (bus.address == STATUS_ADDR);
    assign cycles_sel = (bus.address == CYCLES_ADDR);

    // Writes are suppressed during reset so nothing leaks into RAM or the
    // FIFO storage in the reset cycle.
    assign wr_en = !bus.rw && !reset;

    // ------------------------------------------------------------------
    // RAM (not reset)
    // ------------------------------------------------------------------
    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge clock) begin
        if (wr_en && ram_sel) begin
            ram[bus.address[ADDR_BITS-1:0]] <= bus.datao;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_req;
    logic             push;
    logic             drop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                        (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

    assign pop      = bus.tx_valid && bus.tx_ready;
    assign push_req = wr_en && txdata_sel;
    // When full, a same-cycle pop frees the head slot; the new word is
    // written into that slot and becomes the tail while rd_ptr advances.
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && !push;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr[IDX_W-1:0]] <= bus.datao;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Head is registered storage, so it is stable until a pop moves rd_ptr.
    assign bus.tx_valid = !fifo_empty;
    assign bus.tx_data  = fifo_empty ? 32'd0 : fifo_mem[rd_ptr[IDX_W-1:0]];

    // ------------------------------------------------------------------
    // Sticky overflow flag
    // ------------------------------------------------------------------
    logic overflow;

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (wr_en && status_sel && bus.datao[2]) begin
            overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter: a CPU load wins over the increment; wraps naturally.
    // ------------------------------------------------------------------
    logic [31:0] cycle_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt <= 32'd0;
        end else if (wr_en && cycles_sel) begin
            cycle_cnt <= bus.datao;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Combinational read mux; 0 for writes, reset, TXDATA and unmapped.
    // ------------------------------------------------------------------
    always_comb begin
        bus.data = 32'd0;
        if (bus.rw && !reset) begin
            if (ram_sel) begin
                bus.data = ram[bus.address[ADDR_BITS-1:0]];
            end else if (status_sel) begin
                bus.data = {29'd0, overflow, fifo_empty, fifo_full};
            end else if (cycles_sel) begin
                bus.data = cycle_cnt;
            end
        end
    end

endmodule
